// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with synchronised rows and press/release debounce
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_row,
    output logic [3:0] o_col,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_pulse
);

    localparam int            DW       = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [7:0]    DB_LAST  = 8'(DEBOUNCE_CNT);
    localparam logic          DB_ONE   = (DEBOUNCE_CNT == 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    row_meta_q, row_s_q;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [1:0]    cand_row_q, cand_row_d;
    logic [7:0]    db_cnt_q, db_cnt_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_pulse_q, key_pulse_d;

    logic          tick;
    logic          any_low;
    logic          cand_low;
    logic          db_hit;
    logic [7:0]    db_next;
    logic [1:0]    low_row;
    logic          accept;
    logic          released;

    // Two-flop synchroniser for the asynchronous, pulled-up rows
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
        end else begin
            row_meta_q <= i_row;
            row_s_q    <= row_meta_q;
        end
    end

    // Shared decision terms: dwell tick, lowest low row, candidate level, debounce count
    always_comb begin
        tick     = (div_cnt_q == DIV_LAST);
        any_low  = (row_s_q != 4'hF);
        low_row  = !row_s_q[0] ? 2'd0 : !row_s_q[1] ? 2'd1 : !row_s_q[2] ? 2'd2 : 2'd3;
        cand_low = !row_s_q[cand_row_q];
        db_next  = db_cnt_q + 8'd1;
        db_hit   = (db_next == DB_LAST);
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= SCAN;
        else          state_q <= state_d;
    end

    // FSM next state: every decision is taken only on the dwell tick
    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                SCAN:     state_d = !any_low ? SCAN : DB_ONE ? HELD : DEBOUNCE;
                DEBOUNCE: state_d = !cand_low ? SCAN : db_hit ? HELD : DEBOUNCE;
                HELD:     state_d = cand_low ? HELD : DB_ONE ? SCAN : RELEASE;
                RELEASE:  state_d = cand_low ? HELD : db_hit ? SCAN : RELEASE;
                default:  state_d = SCAN;
            endcase
        end
    end

    // FSM outputs and datapath: column advance, candidate latch, debounce count, key registers
    always_comb begin
        accept      = (state_d == HELD) && (state_q == SCAN || state_q == DEBOUNCE);
        released    = (state_d == SCAN) && (state_q == HELD || state_q == RELEASE);
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        col_idx_d   = (tick && state_d == SCAN) ? col_idx_q + 2'd1 : col_idx_q;
        col_d       = ~(4'b0001 << col_idx_d);
        cand_row_d  = (tick && state_q == SCAN && any_low) ? low_row : cand_row_q;
        db_cnt_d    = db_cnt_q;
        if (tick) begin
            if (state_q == SCAN && any_low)      db_cnt_d = 8'd1;
            if (state_q == DEBOUNCE && cand_low) db_cnt_d = db_next;
            if (state_q == HELD && !cand_low)    db_cnt_d = 8'd1;
            if (state_q == RELEASE && !cand_low) db_cnt_d = db_next;
        end
        key_code_d  = accept ? {cand_row_d, col_idx_q} : key_code_q;
        key_valid_d = accept ? 1'b1 : released ? 1'b0 : key_valid_q;
        key_pulse_d = accept;
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q   <= '0;
            col_idx_q   <= 2'd0;
            cand_row_q  <= 2'd0;
            db_cnt_q    <= 8'd0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_pulse_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            col_idx_q   <= col_idx_d;
            cand_row_q  <= cand_row_d;
            db_cnt_q    <= db_cnt_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    assign o_col       = col_q;
    assign o_key_code  = key_code_q;
    assign o_key_valid = key_valid_q;
    assign o_key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios checked against a tick-level behavioural model
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 3;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [3:0]  i_row;
    logic [3:0]  o_col;
    logic [3:0]  o_key_code;
    logic        o_key_valid;
    logic        o_key_pulse;
    logic [15:0] keys = 16'h0;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    int         m_cyc;
    int         m_col;
    int         m_cand;
    int         m_streak;
    bit         m_locked;
    bit         m_valid;
    bit         m_pulse;
    logic [3:0] m_code;
    logic [3:0] m_d1;
    logic [3:0] m_d2;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_row      (i_row),
        .o_col      (o_col),
        .o_key_code (o_key_code),
        .o_key_valid(o_key_valid),
        .o_key_pulse(o_key_pulse)
    );

    always #5 i_clk = ~i_clk;

    // Keypad matrix: a pressed key (bit r*4+c) pulls row r low while column c is driven low
    always_comb begin
        i_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && o_col[c] === 1'b0) i_row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic model_reset();
        m_cyc = 0; m_col = 0; m_cand = 0; m_streak = 0;
        m_locked = 0; m_valid = 0; m_pulse = 0;
        m_code = 4'h0; m_d1 = 4'hF; m_d2 = 4'hF;
    endtask

    task automatic model_accept();
        m_valid = 1; m_pulse = 1; m_streak = 0;
        m_code = 4'(m_cand * 4 + m_col);
    endtask

    // One clock of the model: rows seen two clocks late, decisions every SD-th clock
    task automatic model_step();
        logic [3:0] rs;
        rs = m_d2; m_d2 = m_d1; m_d1 = i_row;
        m_pulse = 0;
        m_cyc++;
        if (m_cyc % SD != 0) return;
        if (!m_locked) begin
            if (rs != 4'hF) begin
                for (int r = 3; r >= 0; r--) if (!rs[r]) m_cand = r;
                m_locked = 1; m_streak = 1;
                if (m_streak >= DB) model_accept();
            end else m_col = (m_col + 1) % 4;
        end else if (!m_valid) begin
            if (!rs[m_cand]) begin
                m_streak++;
                if (m_streak >= DB) model_accept();
            end else begin
                m_locked = 0; m_col = (m_col + 1) % 4;
            end
        end else begin
            if (rs[m_cand]) begin
                m_streak++;
                if (m_streak >= DB) begin
                    m_valid = 0; m_locked = 0; m_col = (m_col + 1) % 4;
                end
            end else m_streak = 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or negedge i_rst_n);
            if (!i_rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        logic [3:0] ec;
        forever begin
            @(negedge i_clk);
            ec = ~(4'b0001 << m_col);
            check("model_col", o_col, ec);
            check("model_code", o_key_code, m_code);
            check("model_valid", o_key_valid, m_valid);
            check("model_pulse", o_key_pulse, m_pulse);
            if (o_key_pulse === 1'b1) pulses++;
        end
    end

    initial begin
        #1 i_rst_n = 1'b0;
        cyc(3);
        check("rst_col", o_col, 4'b1110);
        check("rst_code", o_key_code, 4'h0);
        check("rst_valid", o_key_valid, 1'b0);
        check("rst_pulse", o_key_pulse, 1'b0);
        i_rst_n = 1'b1;
        cyc(4); check("idle_col1", o_col, 4'b1101);
        cyc(4); check("idle_col2", o_col, 4'b1011);
        cyc(4); check("idle_col3", o_col, 4'b0111);
        cyc(4); check("idle_col0", o_col, 4'b1110);
        check("idle_valid", o_key_valid, 1'b0);
        keys = 16'h0; keys[9] = 1'b1;
        cyc(8);
        check("press_col_frozen", o_col, 4'b1101);
        check("press_valid_early", o_key_valid, 1'b0);
        cyc(7); check("press_valid_before", o_key_valid, 1'b0);
        cyc(1);
        check("press_valid", o_key_valid, 1'b1);
        check("press_pulse", o_key_pulse, 1'b1);
        check("press_code", o_key_code, 4'h9);
        cyc(1);
        check("press_pulse_one", o_key_pulse, 1'b0);
        check("press_pulse_cnt", pulses, 1);
        keys = 16'h0;
        cyc(3); keys[9] = 1'b1;
        cyc(5);
        check("glitch_valid", o_key_valid, 1'b1);
        check("glitch_col", o_col, 4'b1101);
        keys = 16'h0;
        cyc(10); check("release_valid_before", o_key_valid, 1'b1);
        cyc(1);
        check("release_valid", o_key_valid, 1'b0);
        check("release_code", o_key_code, 4'h9);
        check("release_col", o_col, 4'b1011);
        cyc(4);
        check("bounce_col3", o_col, 4'b0111);
        keys[3] = 1'b1;
        cyc(3); keys = 16'h0;
        cyc(4); check("bounce_col_held", o_col, 4'b0111);
        cyc(1);
        check("bounce_col0", o_col, 4'b1110);
        check("bounce_valid", o_key_valid, 1'b0);
        check("bounce_pulse_cnt", pulses, 1);
        keys[2] = 1'b1; keys[14] = 1'b1;
        cyc(20);
        check("multi_valid", o_key_valid, 1'b1);
        check("multi_code", o_key_code, 4'h2);
        check("multi_pulse", o_key_pulse, 1'b1);
        cyc(1); keys[14] = 1'b0;
        cyc(12);
        check("multi_row3_off_valid", o_key_valid, 1'b1);
        check("multi_row3_off_code", o_key_code, 4'h2);
        check("multi_pulse_cnt", pulses, 2);
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_col", o_col, 4'b1110);
        check("async_rst_code", o_key_code, 4'h0);
        check("async_rst_valid", o_key_valid, 1'b0);
        check("async_rst_pulse", o_key_pulse, 1'b0);
        cyc(2); i_rst_n = 1'b1;
        cyc(19); check("repress_valid_before", o_key_valid, 1'b0);
        cyc(1);
        check("repress_valid", o_key_valid, 1'b1);
        check("repress_code", o_key_code, 4'h2);
        cyc(8);
        check("repress_pulse_cnt", pulses, 3);
        keys = 16'h0;
        cyc(16);
        check("final_valid", o_key_valid, 1'b0);
        check("final_code", o_key_code, 4'h2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad and produces a debounced 4-bit key code for the processor's keypad input port. It sits between the board's keypad pins and the core's `i_keypad` input, which the LSU exposes as a memory-mapped input. It drives one column low at a time, synchronises and samples the rows, and debounces both press and release. It reports a held-level valid flag and a one-cycle new-press pulse.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per column dwell; the rows are sampled once per dwell. Legal range is 4 or more.
- `DEBOUNCE_CNT`, default 16: consecutive agreeing samples needed to accept a press or a release. Legal range is 1 to 255.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_row`  in  4  keypad rows.
  - Active-low, externally pulled up, asynchronous to `i_clk`.
- `o_col`  out  4  keypad column drive.
  - Active-low, one-hot-low; all other columns are driven high.
- `o_key_code`  out  4  code of the last accepted key, equal to {row_idx[1:0], col_idx[1:0]}.
- `o_key_valid`  out  1  high while the accepted key is held (after debounce).
- `o_key_pulse`  out  1  high for exactly one cycle when a new press is accepted.

## Operation
- **Row synchroniser**
  - `i_row` passes through a 2-flop synchroniser, reset to 4'hF.
  - All decisions use the synchronised value, `row_s`.
- **Dwell timer**
  - `div_cnt` counts 0 to SCAN_DIV-1, then wraps.
  - The "tick" is the cycle where `div_cnt == SCAN_DIV-1`. The sample, the state decision and any column advance all occur on that edge.
- **Column counter**
  - `col_idx` is 2 bits, and `o_col = ~(4'b0001 << col_idx)`.
  - It wraps from 3 to 0.
  - It advances only in SCAN when no row is low, or when leaving DEBOUNCE or RELEASE back to SCAN.
- **Selected row**
  - When several rows are low, the lowest-index low row wins.
  - The winning row is latched as `cand_row`.
- **FSM**
  - **SCAN**: at a tick, if any bit of `row_s` is low, latch `cand_row`, set `db_cnt = 1` and go to DEBOUNCE. The column is held. Otherwise advance the column.
    - If DEBOUNCE_CNT = 1, accept the press immediately at this tick.
  - **DEBOUNCE**: at each tick:
    - If `row_s[cand_row]` is low, increment `db_cnt`.
    - When `db_cnt` reaches DEBOUNCE_CNT, accept the press and go to HELD.
    - If `row_s[cand_row]` is high, return to SCAN and advance the column. No output changes.
  - **HELD**: the column stays frozen.
    - At a tick, if `row_s[cand_row]` is high, set `db_cnt = 1` and go to RELEASE (or release immediately if DEBOUNCE_CNT = 1).
    - Other keys are ignored.
  - **RELEASE**: at each tick:
    - If `row_s[cand_row]` is high, increment `db_cnt`. At DEBOUNCE_CNT, drop `o_key_valid`, go to SCAN and advance the column.
    - If `row_s[cand_row]` is low, return to HELD.
- **Accept press**
  - `o_key_code <= {cand_row, col_idx}`.
  - `o_key_valid <= 1`.
  - `o_key_pulse <= 1` for one cycle.
- **Outputs after release**
  - `o_key_code` keeps the last accepted code until the next accepted press.

## Timing
- **Reset values**
  - `o_col = 4'b1110` (col 0), `o_key_code = 4'h0`, `o_key_valid = 0`, `o_key_pulse = 0`.
  - FSM is in SCAN, and `div_cnt = 0`, `db_cnt = 0`.
  - Reset asserted at any time, including mid-DEBOUNCE, HELD or RELEASE, forces these values immediately.
- **Registers**
  - All outputs are registered. No combinational path exists from `i_row` to any output.
- **Settling time**
  - Rows are sampled SCAN_DIV-1 cycles after the column changes. This leaves at least SCAN_DIV-3 cycles of settling after the synchroniser delay.
- **Press latency**
  - The key must be stable before the detecting tick.
  - Latency from the detecting tick to the `o_key_valid` rise is (DEBOUNCE_CNT-1)·SCAN_DIV cycles.
  - `o_key_pulse` rises on the same edge as `o_key_valid`.
- **Release latency**
  - `o_key_valid` falls (DEBOUNCE_CNT-1)·SCAN_DIV cycles after the first high tick.
- **Pulses**
  - At most one `o_key_pulse` per accepted press, and none during bounce.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_CNT=3. The bench keypad model pulls a row low while the pressed key's column is driven low.

- **Reset and idle scan**: release reset with no key pressed.
  - `o_col` sequences 1110, 1101, 1011, 0111, 1110, changing every 4 cycles.
  - Outputs stay `code = 0`, `valid = 0`, `pulse = 0`.
- **Stable press**: press row 2 / col 1.
  - `o_col` freezes at 1101.
  - `o_key_valid` rises 8 cycles after the detecting tick, with `o_key_code = 4'h9`.
  - `o_key_pulse` is high for exactly 1 cycle.
- **Bounce**: pull row 0 low for one tick only while col 3 is driven.
  - No `o_key_pulse`, and `o_key_valid` stays 0.
  - Scanning resumes: col 3 then col 0.
- **Release with glitch**: hold row 2 / col 1, then release.
  - A single high tick followed by low keeps `o_key_valid = 1` (RELEASE returns to HELD).
  - Three consecutive high ticks drop `o_key_valid`. `o_key_code` stays 4'h9, and scanning resumes at col 2.
- **Multi-key in one column**: press rows 0 and 3 in col 2 together.
  - `o_key_code = 4'h2` and `valid = 1`.
  - Releasing row 3 alone causes no change.
- **Reset mid-HELD**: assert `i_rst_n = 0` asynchronously, between clock edges.
  - Outputs immediately go to `o_col = 1110`, `code = 0`, `valid = 0`, `pulse = 0`.
  - After reset releases with the key still held, a fresh press is accepted with exactly one pulse.
